store_commit_buffer: RTL and testbench

//  Parametrised in-order store buffer between the load/store unit and data memory.

---
 rtl/store_commit_buffer.sv | 156 +++++++++++++++
 tb/tb_store_commit_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/store_commit_buffer.sv
// rtl/store_commit_buffer.sv - in-order store buffer: commit tracking, drain to memory, load forwarding
module store_commit_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [2:0]                 st_func3,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic [TAG_W-1:0]           st_inst_num,
  input  logic                       commit_valid,
  input  logic [TAG_W-1:0]           commit_inst_num,
  output logic                       commit_err,
  input  logic                       flush,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [2:0]                 mem_func3,
  input  logic                       mem_ready,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [2:0]                 ld_func3,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic                       fwd_stall,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] F3_WORD = 3'b010;

  logic [ADDR_W-1:0] e_addr  [DEPTH];
  logic [DATA_W-1:0] e_data  [DEPTH];
  logic [2:0]        e_func3 [DEPTH];
  logic [TAG_W-1:0]  e_tag   [DEPTH];
  logic [DEPTH-1:0]  e_valid;
  logic [DEPTH-1:0]  e_cmtd;

  logic [PW-1:0] head, cmt, tail;
  logic [CW-1:0] count_q;

  logic          enq, cmt_ok, drain, head_cmtd_next;
  logic [PW-1:0] cmt_next, cmt_span;
  logic [CW-1:0] keep_cnt, count_next;

  assign count    = count_q;
  assign st_ready = (count_q != CW'(DEPTH));
  assign mem_we   = (count_q != '0) && e_valid[head] && e_cmtd[head];

  assign mem_addr  = mem_we ? e_addr[head]  : '0;
  assign mem_wdata = mem_we ? e_data[head]  : '0;
  assign mem_func3 = mem_we ? e_func3[head] : 3'b000;

  // Entry-state based commit check: cmt==tail is ambiguous when the buffer is full.
  assign enq    = st_valid && st_ready && !flush;
  assign cmt_ok = commit_valid && e_valid[cmt] && !e_cmtd[cmt] &&
                  (commit_inst_num == e_tag[cmt]);
  assign drain  = mem_we && mem_ready;

  assign cmt_next       = cmt_ok ? cmt + 1'b1 : cmt;
  assign cmt_span       = cmt_next - head;
  assign head_cmtd_next = e_valid[head] && (e_cmtd[head] || (cmt_ok && (cmt == head)));

  // Committed entries surviving a flush; a full ring of committed stores wraps to DEPTH.
  always_comb begin
    keep_cnt = CW'(cmt_span);
    if (cmt_next == head)
      keep_cnt = head_cmtd_next ? CW'(DEPTH) : '0;
    if (flush)
      count_next = keep_cnt - CW'(drain);
    else
      count_next = count_q + CW'(enq) - CW'(drain);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head       <= '0;
      cmt        <= '0;
      tail       <= '0;
      count_q    <= '0;
      commit_err <= 1'b0;
      e_valid    <= '0;
      e_cmtd     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i]  <= '0;
        e_data[i]  <= '0;
        e_func3[i] <= '0;
        e_tag[i]   <= '0;
      end
    end else begin
      commit_err <= commit_valid && !cmt_ok;
      if (enq) begin
        e_addr[tail]  <= st_addr;
        e_data[tail]  <= st_data;
        e_func3[tail] <= st_func3;
        e_tag[tail]   <= st_inst_num;
        e_valid[tail] <= 1'b1;
        e_cmtd[tail]  <= 1'b0;
      end
      if (cmt_ok)
        e_cmtd[cmt] <= 1'b1;
      if (drain) begin
        e_valid[head] <= 1'b0;
        e_cmtd[head]  <= 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (e_valid[i] && !e_cmtd[i] && !(cmt_ok && (cmt == PW'(i))))
            e_valid[i] <= 1'b0;
        end
      end
      head    <= drain ? head + 1'b1 : head;
      cmt     <= cmt_next;
      tail    <= flush ? cmt_next : (enq ? tail + 1'b1 : tail);
      count_q <= count_next;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  logic          m_found;
  logic [PW-1:0] m_idx, walk_idx;

  always_comb begin
    m_found  = 1'b0;
    m_idx    = '0;
    walk_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      walk_idx = head + PW'(k);
      if (e_valid[walk_idx] && (e_addr[walk_idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        m_found = 1'b1;
        m_idx   = walk_idx;
      end
    end
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    if (ld_valid && m_found) begin
      if ((e_func3[m_idx] == F3_WORD) && (ld_func3 == F3_WORD)) begin
        fwd_hit  = 1'b1;
        fwd_data = e_data[m_idx];
      end else begin
        fwd_stall = 1'b1;
      end
    end
  end

  logic unused_ld_bits;
  assign unused_ld_bits = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_commit_buffer.sv
// tb/tb_store_commit_buffer.sv - directed bench for store_commit_buffer
module tb_store_commit_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, st_ready;
  logic [2:0]  st_func3;
  logic [31:0] st_addr, st_data, st_inst_num;
  logic        commit_valid;
  logic [31:0] commit_inst_num;
  logic        commit_err, flush;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_func3;
  logic        mem_ready, ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_func3;
  logic        fwd_hit, fwd_stall;
  logic [31:0] fwd_data;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] SW = 3'b010;
  localparam logic [2:0] SB = 3'b000;

  store_commit_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_func3(st_func3),
    .st_addr(st_addr), .st_data(st_data), .st_inst_num(st_inst_num),
    .commit_valid(commit_valid), .commit_inst_num(commit_inst_num),
    .commit_err(commit_err), .flush(flush),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_ready(mem_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_func3(ld_func3),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] t, input logic [2:0] f);
    st_valid = 1'b1; st_addr = a; st_data = d; st_inst_num = t; st_func3 = f;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [31:0] t);
    commit_valid = 1'b1; commit_inst_num = t;
    tick();
    commit_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_func3 = '0; st_addr = '0; st_data = '0;
    st_inst_num = '0; commit_valid = 1'b0; commit_inst_num = '0; flush = 1'b0;
    mem_ready = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_func3 = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_count", count, 0);
    chk("rst_st_ready", st_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_commit_err", commit_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fwd", {fwd_hit, fwd_stall}, 0);

    // in-order commit and drain
    push(32'h10, 32'hD0, 10, SW);
    push(32'h14, 32'hD1, 11, SW);
    push(32'h18, 32'hD2, 12, SW);
    chk("t1_count3", count, 3);
    chk("t1_no_we", mem_we, 0);
    mem_ready = 1'b1;
    do_commit(10);
    chk("t1_we_after_c10", mem_we, 1);
    chk("t1_addr0", mem_addr, 32'h10);
    chk("t1_data0", mem_wdata, 32'hD0);
    do_commit(11);
    chk("t1_addr1", mem_addr, 32'h14);
    chk("t1_count2", count, 2);
    do_commit(12);
    chk("t1_addr2", mem_addr, 32'h18);
    chk("t1_data2", mem_wdata, 32'hD2);
    chk("t1_count1", count, 1);
    chk("t1_no_err", commit_err, 0);
    tick();
    chk("t1_count0", count, 0);
    chk("t1_we_off", mem_we, 0);

    // full buffer
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h200 + 4 * i, 32'h1000 + i, 100 + i, SW);
    chk("t2_full_count", count, 8);
    chk("t2_not_ready", st_ready, 0);
    push(32'h300, 32'hBAD, 200, SW);
    chk("t2_ninth_ignored", count, 8);
    do_commit(100);
    chk("t2_we", mem_we, 1);
    chk("t2_addr", mem_addr, 32'h200);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("t2_ready_again", st_ready, 1);
    chk("t2_count7", count, 7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t2_flush_count", count, 0);
    chk("t2_flush_we", mem_we, 0);

    // flush with same-cycle commit
    for (int i = 0; i < 4; i++) push(32'h300 + 4 * i, 32'h2000 + i, 20 + i, SW);
    do_commit(20);
    flush = 1'b1; commit_valid = 1'b1; commit_inst_num = 21;
    tick();
    flush = 1'b0; commit_valid = 1'b0;
    chk("t3_count2", count, 2);
    chk("t3_addr20", mem_addr, 32'h300);
    chk("t3_err_none", commit_err, 0);
    mem_ready = 1'b1;
    tick();
    chk("t3_addr21", mem_addr, 32'h304);
    chk("t3_data21", mem_wdata, 32'h2001);
    chk("t3_count1", count, 1);
    tick();
    chk("t3_count0", count, 0);
    chk("t3_we_off", mem_we, 0);
    mem_ready = 1'b0;
    do_commit(22);
    chk("t3_err22", commit_err, 1);
    tick();
    chk("t3_err_pulse", commit_err, 0);

    // wrong-tag commit, then stall and reset mid-drain
    push(32'h400, 32'hCAFEF00D, 30, SW);
    do_commit(31);
    chk("t4_err", commit_err, 1);
    chk("t4_count", count, 1);
    chk("t4_no_we", mem_we, 0);
    tick();
    chk("t4_err_clear", commit_err, 0);
    do_commit(30);
    for (int i = 0; i < 5; i++) begin
      chk("t6_we_hold", mem_we, 1);
      chk("t6_addr_hold", mem_addr, 32'h400);
      chk("t6_data_hold", mem_wdata, 32'hCAFEF00D);
      chk("t6_f3_hold", mem_func3, SW);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_we", mem_we, 0);

    // forwarding
    push(32'h100, 32'hAAAA0000, 40, SW);
    push(32'h100, 32'h12345678, 41, SW);
    ld_valid = 1'b1; ld_addr = 32'h100; ld_func3 = SW;
    #1;
    chk("t5_hit", fwd_hit, 1);
    chk("t5_data", fwd_data, 32'h12345678);
    chk("t5_nostall", fwd_stall, 0);
    ld_addr = 32'h104;
    #1;
    chk("t5_miss", {fwd_hit, fwd_stall}, 0);
    chk("t5_miss_data", fwd_data, 0);
    ld_addr = 32'h103; ld_func3 = 3'b000;
    #1;
    chk("t5_lb_stall", {fwd_hit, fwd_stall}, 2'b01);
    ld_addr = 32'h100; ld_func3 = SW;
    st_valid = 1'b1; st_addr = 32'h102; st_data = 32'hFF; st_inst_num = 42; st_func3 = SB;
    #1;
    chk("t5_same_cycle_invisible", fwd_hit, 1);
    tick();
    st_valid = 1'b0;
    #1;
    chk("t5_sb_stall", fwd_stall, 1);
    chk("t5_sb_nohit", fwd_hit, 0);
    ld_valid = 1'b0;
    #1;
    chk("t5_idle", {fwd_hit, fwd_stall}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
